// File: rtl/arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package arb_pkg;

    typedef enum logic {
        CPU_OWN = 1'b0,
        LD_OWN  = 1'b1
    } owner_t;

    localparam int MAX_WAIT_DEF  = 8;
    localparam int BURST_MAX_DEF = 16;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_LD  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_counter.sv
// Wrap/clear counter over 0..MAX-1, clear has priority; tc_o flags MAX-1.
// Registered count, terminal count is combinational from the register.
module arb_counter
    import arb_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int W = cnt_width(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == W'(MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-cycle data-memory port between the CPU memory stage and a loader.
// Zero-latency grant; CPU stalls while the loader owns memory, loader waits up to MAX_WAIT.
module data_mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_re_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic          ld_last_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    output logic          ld_gnt_o,
    output logic [DW-1:0] ld_rdata_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    owner_t owner_q, owner_d;
    logic   cpu_req;
    logic   sel;
    logic   wait_inc, wait_tc;
    logic   beat_inc, beat_tc;

    assign cpu_req     = cpu_re_i | cpu_we_i;
    assign cpu_rdata_o = mem_rdata_i;
    assign ld_rdata_o  = mem_rdata_i;
    assign mem_addr_o  = (sel == SEL_LD) ? ld_addr_i  : cpu_addr_i;
    assign mem_wdata_o = (sel == SEL_LD) ? ld_wdata_i : cpu_wdata_i;

    always_comb begin
        owner_d     = owner_q;
        sel         = SEL_CPU;
        mem_we_o    = 1'b0;
        ld_gnt_o    = 1'b0;
        cpu_stall_o = 1'b0;
        wait_inc    = 1'b0;
        beat_inc    = 1'b0;
        case (owner_q)
            CPU_OWN: begin
                if (cpu_req) begin
                    mem_we_o = cpu_we_i;
                    if (ld_req_i) begin
                        // Wait counter wraps to zero on the forced hand-over.
                        wait_inc = 1'b1;
                        if (wait_tc) owner_d = LD_OWN;
                    end
                end else begin
                    sel = SEL_LD;
                    if (ld_req_i) begin
                        ld_gnt_o = 1'b1;
                        mem_we_o = ld_we_i;
                        // beat_tc here means a one-beat limit: the burst is already spent.
                        if (!ld_last_i && !beat_tc) begin
                            beat_inc = 1'b1;
                            owner_d  = LD_OWN;
                        end
                    end
                end
            end
            LD_OWN: begin
                sel         = SEL_LD;
                cpu_stall_o = cpu_req;
                ld_gnt_o    = ld_req_i;
                mem_we_o    = ld_req_i & ld_we_i;
                if (ld_req_i && !ld_last_i && !beat_tc) begin
                    beat_inc = 1'b1;
                end else begin
                    owner_d = CPU_OWN;
                end
            end
            default: owner_d = CPU_OWN;
        endcase
        if (!rst_i) begin
            sel         = SEL_CPU;
            mem_we_o    = 1'b0;
            ld_gnt_o    = 1'b0;
            cpu_stall_o = 1'b0;
            owner_d     = CPU_OWN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            owner_q <= CPU_OWN;
        end else begin
            owner_q <= owner_d;
        end
    end

    arb_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wait_inc),
        .clr_i (!wait_inc),
        .tc_o  (wait_tc)
    );

    arb_counter #(.MAX(BURST_MAX)) u_beat_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (beat_inc),
        .clr_i (!beat_inc),
        .tc_o  (beat_tc)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then random traffic, checked
// against a cycle-level reference model of ownership, waits and burst beats.
module tb_data_mem_arbiter;

    localparam int MW = 8;
    localparam int BM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we, ld_req, ld_we, ld_last;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic        cpu_stall, ld_gnt, mem_we;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW), .BURST_MAX(BM)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_re_i    (cpu_re),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .ld_req_i    (ld_req),
        .ld_we_i     (ld_we),
        .ld_last_i   (ld_last),
        .ld_addr_i   (ld_addr),
        .ld_wdata_i  (ld_wdata),
        .ld_gnt_o    (ld_gnt),
        .ld_rdata_o  (ld_rdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: loader ownership flag, consecutive denied cycles, beats this period.
    bit m_own_ld = 0;
    int m_denied = 0;
    int m_beats  = 0;
    bit m_gnt, m_srv;

    task automatic step();
        bit          creq, e_we, e_gnt, e_stall, a_vld;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        creq = cpu_re | cpu_we;
        e_we = 0; e_gnt = 0; e_stall = 0; a_vld = 0; m_srv = 0;
        e_addr = '0; e_wd = '0;
        if (!rst) begin
            e_addr = cpu_addr; a_vld = 1;
            m_own_ld = 0; m_denied = 0; m_beats = 0;
        end else if (!m_own_ld) begin
            if (creq) begin
                m_srv = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; a_vld = 1;
                if (ld_req) begin
                    m_denied++;
                    if (m_denied == MW) begin m_own_ld = 1; m_denied = 0; end
                end else m_denied = 0;
            end else if (ld_req) begin
                e_gnt = 1; e_we = ld_we; e_addr = ld_addr; e_wd = ld_wdata; a_vld = 1;
                m_denied = 0;
                if (!ld_last && BM > 1) begin m_own_ld = 1; m_beats = 1; end
            end else m_denied = 0;
        end else begin
            e_stall = creq; e_gnt = ld_req; e_we = ld_req && ld_we;
            e_addr = ld_addr; e_wd = ld_wdata; a_vld = 1;
            if (ld_req) begin
                m_beats++;
                if (ld_last || m_beats == BM) begin m_own_ld = 0; m_beats = 0; end
            end else begin
                m_own_ld = 0; m_beats = 0;
            end
        end
        check("cpu_stall", cpu_stall, e_stall);
        check("ld_gnt", ld_gnt, e_gnt);
        check("mem_we", mem_we, e_we);
        if (a_vld) check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
        if (m_srv && cpu_re && !cpu_we) check("cpu_rdata", cpu_rdata, shadow[cpu_addr[9:2]]);
        if (e_gnt && !ld_we) check("ld_rdata", ld_rdata, shadow[ld_addr[9:2]]);
        if (e_we) shadow[e_addr[9:2]] = e_wd;
        m_gnt = e_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ld(input bit req, input bit we, input bit last,
                          input logic [31:0] a, input logic [31:0] d);
        ld_req = req; ld_we = we; ld_last = last; ld_addr = a; ld_wdata = d;
    endtask

    task automatic idle();
        set_cpu(0, 0, 32'h0, 32'h0);
        set_ld(0, 0, 0, 32'h0, 32'h0);
    endtask

    // Loader write burst of n beats; the CPU loads from beat cpu_from until served once.
    task automatic burst(input int n, input logic [31:0] base, input int cpu_from);
        int beat = 0;
        bit srv_once = 0;
        for (int c = 0; c < 4 * n + 20 && beat < n; c++) begin
            set_ld(1, 1, beat == n - 1, base + 32'(4 * beat), 32'hB000_0000 + 32'(beat));
            set_cpu(beat >= cpu_from && !srv_once, 0, base, 32'h0);
            step();
            if (m_srv && cpu_re) srv_once = 1;
            if (m_gnt) beat++;
        end
        check("burst_beats", beat, n);
        check("burst_cpu_served", srv_once, cpu_from < n);
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA500_0000 + 32'(i);
            shadow[i] = 32'hA500_0000 + 32'(i);
        end
        rst = 0;
        idle();
        set_cpu(0, 1, 32'h40, 32'h1234_5678);
        set_ld(1, 1, 0, 32'h80, 32'h5555_AAAA);
        step();
        step();
        rst = 1;
        idle();

        set_cpu(0, 1, 32'h40, 32'hDEAD_BEEF);
        step();
        set_cpu(1, 0, 32'h40, 32'h0);
        step();
        idle();

        for (int b = 0; b < 4; b++) begin
            set_ld(1, 1, b == 3, 32'h100 + 32'(4 * b), 32'hC000_0000 + 32'(b));
            set_cpu(b >= 1, 0, 32'h104, 32'h0);
            step();
        end
        set_ld(0, 0, 0, 32'h0, 32'h0);
        step();
        idle();
        step();

        for (int c = 0; c < MW + 1; c++) begin
            set_cpu(1, 0, 32'h10C, 32'h0);
            set_ld(1, 0, 1, 32'h108, 32'h0);
            step();
        end
        idle();
        step();

        burst(20, 32'h200, 10);

        for (int b = 0; b < 2; b++) begin
            set_ld(1, 1, 0, 32'h380 + 32'(4 * b), 32'hD000_0000 + 32'(b));
            step();
        end
        idle();
        step();
        set_cpu(1, 0, 32'h380, 32'h0);
        step();
        idle();

        burst(17, 32'h300, 1);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            set_cpu($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            set_ld($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7) == 0,
                   {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
            step();
        end
        rst = 1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
